// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default width and FSM state encoding.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  // Encoding 2'd3 is unused and recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus of the bit-serial adder.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic             iSTART;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iCIN;
  logic             oREADY;
  logic             oBUSY;
  logic             oDONE;
  logic [WIDTH-1:0] oSUM;
  logic             oCOUT;

  modport master (
    output iSTART, iA, iB, iCIN,
    input  oREADY, oBUSY, oDONE, oSUM, oCOUT
  );

  modport slave (
    input  iSTART, iA, iB, iCIN,
    output oREADY, oBUSY, oDONE, oSUM, oCOUT
  );

endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell, evaluated once per clock by serial_adder.
module full_adder (
  input  logic iX,
  input  logic iY,
  input  logic iCIN,
  output logic oSUM,
  output logic oCARRY
);

  assign oSUM   = iX ^ iY ^ iCIN;
  assign oCARRY = (iX & iY) | (iCIN & (iX ^ iY));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full_adder cell, WIDTH cycles per addition,
// start/done handshake on the bus interface.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic           iCLK,
  input logic           iRSTn,
  serial_adder_if.slave bus
);

  localparam int unsigned    CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LastCnt = CW'(WIDTH - 1);

  state_t           stateQ;
  logic [WIDTH-1:0] shAQ;
  logic [WIDTH-1:0] shBQ;
  logic [WIDTH-1:0] sumQ;
  logic             carryQ;
  logic [CW-1:0]    cntQ;
  logic             faSum;
  logic             faCarry;

  full_adder uFullAdder (
    .iX    (shAQ[0]),
    .iY    (shBQ[0]),
    .iCIN  (carryQ),
    .oSUM  (faSum),
    .oCARRY(faCarry)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      stateQ <= StIdle;
      shAQ   <= '0;
      shBQ   <= '0;
      sumQ   <= '0;
      carryQ <= 1'b0;
      cntQ   <= '0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (bus.iSTART) begin
            shAQ   <= bus.iA;
            shBQ   <= bus.iB;
            carryQ <= bus.iCIN;
            cntQ   <= '0;
            stateQ <= StRun;
          end
        end
        StRun: begin
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 holds the LSB.
          sumQ   <= (sumQ >> 1) | (WIDTH'(faSum) << (WIDTH - 1));
          shAQ   <= shAQ >> 1;
          shBQ   <= shBQ >> 1;
          carryQ <= faCarry;
          cntQ   <= cntQ + 1'b1;
          if (cntQ == LastCnt) begin
            stateQ <= StDone;
          end
        end
        StDone: begin
          stateQ <= StIdle;
        end
        default: begin
          stateQ <= StIdle;
        end
      endcase
    end
  end

  // Handshake flags are pure decodes of the state register.
  assign bus.oREADY = (stateQ == StIdle);
  assign bus.oBUSY  = (stateQ == StRun);
  assign bus.oDONE  = (stateQ == StDone);
  assign bus.oSUM   = sumQ;
  assign bus.oCOUT  = carryQ;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
  import serial_adder_pkg::*;

  typedef struct {
    logic [8:0] res;
    int         doneCyc;
  } exp_t;

  logic iCLK  = 1'b0;
  logic iRSTn = 1'b0;
  always #5 iCLK = ~iCLK;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .iCLK (iCLK),
    .iRSTn(iRSTn),
    .bus  (bus8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .iCLK (iCLK),
    .iRSTn(iRSTn),
    .bus  (bus1)
  );

  exp_t sb8[$];
  exp_t sb1[$];
  int   nTests    = 0;
  int   nFail     = 0;
  int   cyc       = 0;
  int   busyCnt   = 0;
  int   doneCnt   = 0;
  int   acceptCnt = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge iCLK) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever a DUT signals done.
  always @(negedge iCLK) begin : monitor
    exp_t e;
    if (bus8.oBUSY) busyCnt++;
    if (bus8.oDONE) begin
      doneCnt++;
      if (sb8.size() == 0) begin
        checkVal("done8_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb8.pop_front();
        checkVal("result8", {55'd0, bus8.oCOUT, bus8.oSUM}, {55'd0, e.res});
        checkVal("latency8", 64'(cyc), 64'(e.doneCyc));
      end
    end
    if (bus1.oDONE) begin
      if (sb1.size() == 0) begin
        checkVal("done1_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb1.pop_front();
        checkVal("result1", {62'd0, bus1.oCOUT, bus1.oSUM}, {55'd0, e.res});
        checkVal("latency1", 64'(cyc), 64'(e.doneCyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic startOp8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int t;
    t = 0;
    while (!bus8.oREADY && t < 50) begin
      @(negedge iCLK);
      t++;
    end
    if (!bus8.oREADY) begin
      checkVal("ready8_timeout", 64'd0, 64'd1);
      return;
    end
    bus8.iA     = a;
    bus8.iB     = b;
    bus8.iCIN   = cin;
    bus8.iSTART = 1'b1;
    sb8.push_back('{res: 9'(a) + 9'(b) + 9'(cin), doneCyc: cyc + 9});
    acceptCnt++;
    @(negedge iCLK);
    bus8.iSTART = 1'b0;
  endtask

  task automatic startOp1(input logic a, input logic b, input logic cin);
    int t;
    t = 0;
    while (!bus1.oREADY && t < 50) begin
      @(negedge iCLK);
      t++;
    end
    if (!bus1.oREADY) begin
      checkVal("ready1_timeout", 64'd0, 64'd1);
      return;
    end
    bus1.iA     = a;
    bus1.iB     = b;
    bus1.iCIN   = cin;
    bus1.iSTART = 1'b1;
    sb1.push_back('{res: 9'(a) + 9'(b) + 9'(cin), doneCyc: cyc + 2});
    @(negedge iCLK);
    bus1.iSTART = 1'b0;
  endtask

  // Returns at a negedge in IDLE with the scoreboard drained.
  task automatic waitIdle8(input bit scramble);
    int t;
    t = 0;
    while ((sb8.size() != 0 || !bus8.oREADY) && t < 100) begin
      @(negedge iCLK);
      if (scramble) begin
        bus8.iA   = 8'($urandom);
        bus8.iB   = 8'($urandom);
        bus8.iCIN = 1'($urandom);
      end
      t++;
    end
    if (t >= 100) checkVal("idle8_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitIdle1();
    int t;
    t = 0;
    while ((sb1.size() != 0 || !bus1.oREADY) && t < 20) begin
      @(negedge iCLK);
      t++;
    end
    if (t >= 20) checkVal("idle1_timeout", 64'd0, 64'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [2:0] pats[8];
    int         d0;
    pats = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};

    bus8.iSTART = 1'b0; bus8.iA = '0; bus8.iB = '0; bus8.iCIN = 1'b0;
    bus1.iSTART = 1'b0; bus1.iA = '0; bus1.iB = '0; bus1.iCIN = 1'b0;

    #1;
    checkVal("rst_ready", 64'(bus8.oREADY), 64'd1);
    checkVal("rst_busy",  64'(bus8.oBUSY),  64'd0);
    checkVal("rst_done",  64'(bus8.oDONE),  64'd0);
    checkVal("rst_sum",   64'(bus8.oSUM),   64'd0);
    checkVal("rst_cout",  64'(bus8.oCOUT),  64'd0);
    repeat (2) @(negedge iCLK);
    iRSTn = 1'b1;
    @(negedge iCLK);

    // Basic addition, latency and busy length.
    busyCnt = 0;
    startOp8(8'h5A, 8'hA5, 1'b0);
    waitIdle8(1'b0);
    checkVal("busy_cycles", 64'(busyCnt), 64'd8);

    // Carry out, then back-to-back start on the next ready.
    startOp8(8'hFF, 8'h01, 1'b0);
    waitIdle8(1'b0);
    startOp8(8'hFF, 8'hFF, 1'b1);
    waitIdle8(1'b0);

    // Start during RUN is ignored; result holds afterwards.
    d0 = doneCnt;
    startOp8(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge iCLK);
    bus8.iA = 8'hFF; bus8.iB = 8'hFF; bus8.iSTART = 1'b1;
    @(negedge iCLK);
    bus8.iSTART = 1'b0;
    waitIdle8(1'b0);
    checkVal("single_done", 64'(doneCnt - d0), 64'd1);
    for (int i = 0; i < 5; i++) begin
      checkVal("hold_sum", 64'(bus8.oSUM), 64'h30);
      @(negedge iCLK);
    end

    // Reset mid-RUN aborts with no done.
    d0 = doneCnt;
    startOp8(8'h7F, 8'h01, 1'b0);
    repeat (3) @(negedge iCLK);
    iRSTn = 1'b0;
    #1;
    checkVal("abort_ready", 64'(bus8.oREADY), 64'd1);
    checkVal("abort_busy",  64'(bus8.oBUSY),  64'd0);
    checkVal("abort_done",  64'(bus8.oDONE),  64'd0);
    checkVal("abort_sum",   64'(bus8.oSUM),   64'd0);
    checkVal("abort_cout",  64'(bus8.oCOUT),  64'd0);
    sb8.delete();
    acceptCnt--;
    @(negedge iCLK);
    iRSTn = 1'b1;
    repeat (12) @(negedge iCLK);
    checkVal("abort_no_done", 64'(doneCnt - d0), 64'd0);
    checkVal("abort_ready_after", 64'(bus8.oREADY), 64'd1);
    startOp8(8'h03, 8'h04, 1'b0);
    waitIdle8(1'b0);
    checkVal("after_abort_sum", 64'(bus8.oSUM), 64'h07);

    // WIDTH=1: full adder truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] p;
      p = pats[i];
      startOp1(p[2], p[1], p[0]);
      waitIdle1();
    end

    // Random operands with inputs scrambled during RUN.
    for (int i = 0; i < 200; i++) begin
      startOp8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom));
      waitIdle8(1'b1);
    end

    repeat (3) @(negedge iCLK);
    checkVal("done_vs_accept", 64'(doneCnt), 64'(acceptCnt));
    checkVal("sb_drained", 64'(sb8.size() + sb1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
